// File: rtl/img2col_pkg.sv
`default_nettype none
// ============================================================================
// img2col_pkg : FSM states and geometry constants shared by the img2col PU
// Revision    : 1.0
// ============================================================================
package img2col_pkg;

  localparam int KERNEL        = 5;
  localparam int ADDR_W        = 5;
  localparam int BEATS_PER_COL = (KERNEL + 1) / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_e;

  // Counter width that stays legal (>= 1 bit) for single-value ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beats_per_col(input int k);
    return (k + 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pu_col_counter.sv
`default_nettype none
// ============================================================================
// pu_col_counter : nested column/row step counter with terminal flags and the
//                  registered neighbour-valid (round) flag.     Revision : 1.0
// ============================================================================
module pu_col_counter
  import img2col_pkg::*;
#(
  parameter int cols   = 28,
  parameter int rows   = 24,
  parameter int kernel = KERNEL
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear_i,
  input  logic step_i,
  output logic col_last_o,
  output logic row_last_o,
  output logic round_o
);

  localparam int               COL_W         = cnt_width(cols);
  localparam int               ROW_W         = cnt_width(rows);
  localparam logic [COL_W-1:0] COL_MAX       = COL_W'(cols - 1);
  localparam logic [ROW_W-1:0] ROW_MAX       = ROW_W'(rows - 1);
  localparam logic             ROUND_AT_ZERO = (kernel <= 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             round_q, round_d;

  assign col_last_o = (col_q == COL_MAX);
  assign row_last_o = (row_q == ROW_MAX);
  assign round_o    = round_q;

  // Both counters saturate at their terminal value; the FSM ends the frame there.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    round_d = round_q;
    if (clear_i) begin
      col_d   = '0;
      row_d   = '0;
      round_d = ROUND_AT_ZERO;
    end else if (step_i) begin
      if (!col_last_o) begin
        col_d   = col_q + 1'b1;
        round_d = ((int'(col_q) + 1) >= (kernel - 1));
      end else if (!row_last_o) begin
        col_d   = '0;
        row_d   = row_q + 1'b1;
        round_d = ROUND_AT_ZERO;
      end
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      col_q   <= '0;
      row_q   <= '0;
      round_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      round_q <= round_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pu_col_feeder.sv
`default_nettype none
// ============================================================================
// pu_col_feeder : repacks a 2-pixel stream into kernel-pixel columns written
//                 into the PU "new" register file.           Revision : 1.0
// ============================================================================
module pu_col_feeder
  import img2col_pkg::*;
#(
  parameter int data_width  = 16,
  parameter int address_num = ADDR_W,
  parameter int kernel      = KERNEL,
  parameter int cols        = 28,
  parameter int rows        = 24
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   frame_start,
  input  logic [data_width-1:0]  s_data1,
  input  logic [data_width-1:0]  s_data2,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   pu_ack,
  output logic [data_width-1:0]  new1,
  output logic [data_width-1:0]  new2,
  output logic [address_num-1:0] adrs_in1,
  output logic [address_num-1:0] adrs_in2,
  output logic                   wr_valid,
  output logic                   start,
  output logic                   round,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int                BEATS      = beats_per_col(kernel);
  localparam int                BEAT_W     = cnt_width(BEATS);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);
  localparam logic              ODD_KERNEL = ((kernel % 2) != 0);

  state_e                 state_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   ack_seen_q;
  logic                   start_q;
  logic                   busy_q;
  logic                   frame_done_q;
  logic                   wr_valid_q;
  logic [data_width-1:0]  new1_q, new2_q;
  logic [address_num-1:0] adrs1_q, adrs2_q;

  logic                   beat_hs;
  logic                   last_beat;
  logic                   frame_go;
  logic                   wait_exit;
  logic                   frame_end;
  logic                   cnt_step;
  logic                   col_last;
  logic                   row_last;
  logic [address_num-1:0] wr_adrs;

  assign s_ready   = (state_q == LOAD);
  assign beat_hs   = s_ready & s_valid;
  assign last_beat = (beat_q == BEAT_LAST);
  assign wr_adrs   = address_num'({beat_q, 1'b0});
  // frame_done_q blocks a frame_start arriving in the same cycle as the done pulse.
  assign frame_go  = (state_q == IDLE) & frame_start & ~frame_done_q;
  assign wait_exit = (state_q == WAIT) & (ack_seen_q | pu_ack);
  assign frame_end = col_last & row_last;
  assign cnt_step  = wait_exit & ~frame_end;

  pu_col_counter #(
    .cols   (cols),
    .rows   (rows),
    .kernel (kernel)
  ) u_counter (
    .clk        (clk),
    .nrst       (nrst),
    .clear_i    (frame_go),
    .step_i     (cnt_step),
    .col_last_o (col_last),
    .row_last_o (row_last),
    .round_o    (round)
  );

  // START is the cycle the last write is presented; the registered start pulse
  // therefore lands one cycle later, after every entry has been written.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      ack_seen_q   <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_go) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            beat_q     <= '0;
            ack_seen_q <= 1'b0;
          end
        end
        LOAD: begin
          if (beat_hs) begin
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= START;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        START: begin
          start_q <= 1'b1;
          state_q <= WAIT;
          if (pu_ack) ack_seen_q <= 1'b1;
        end
        WAIT: begin
          if (wait_exit) begin
            ack_seen_q <= 1'b0;
            if (frame_end) begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      wr_valid_q <= 1'b0;
      new1_q     <= '0;
      new2_q     <= '0;
      adrs1_q    <= '0;
      adrs2_q    <= '0;
    end else begin
      wr_valid_q <= beat_hs;
      if (beat_hs) begin
        new1_q  <= s_data1;
        adrs1_q <= wr_adrs;
        if (last_beat && ODD_KERNEL) begin
          new2_q  <= s_data1;
          adrs2_q <= wr_adrs;
        end else begin
          new2_q  <= s_data2;
          adrs2_q <= wr_adrs + address_num'(1);
        end
      end
    end
  end

  assign new1       = new1_q;
  assign new2       = new2_q;
  assign adrs_in1   = adrs1_q;
  assign adrs_in2   = adrs2_q;
  assign wr_valid   = wr_valid_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
